// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch with IF/ID register, one-word skid buffer,
//            redirect and halt handling. Optional FETCH_PERF_CNT_EN macro
//            adds fetched/bubble performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_b,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_valid;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc_plus4;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubbles;
    assign perf_fetched = r_perf_fetched;
    assign perf_bubbles = r_perf_bubbles;
`endif

    // Branch wins over jump: it belongs to the older instruction.
    assign w_redirect = branch_taken | jump;
    assign w_target   = branch_taken ? {branch_target[31:2], 2'b00}
                                     : {jump_target[31:2], 2'b00};
    assign w_pc_plus4 = r_pc + 32'd4;

    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = {r_pc[31:2], 2'b00};
    assign if_instr    = r_instr;
    assign if_pc_plus4 = r_pc_plus4;
    assign if_valid    = r_valid;
    assign halted      = (r_state == S_HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_FETCH;
            r_pc            <= RESET_PC;
            r_instr         <= NOP_INSTR;
            r_pc_plus4      <= 32'd0;
            r_valid         <= 1'b0;
            r_skid_instr    <= NOP_INSTR;
            r_skid_pc_plus4 <= 32'd0;
`ifdef FETCH_PERF_CNT_EN
            r_perf_fetched  <= 32'd0;
            r_perf_bubbles  <= 32'd0;
`endif
        end else if (halt) begin
            r_state <= S_HALTED;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (r_state == S_HALTED) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (w_redirect) begin
            // Any in-flight response and the skid word are dropped here.
            r_state <= S_FETCH;
            r_pc    <= w_target;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
            r_perf_bubbles <= r_perf_bubbles + 32'd1;
`endif
        end else if (r_state == S_FETCH) begin
            if (imem_ready) begin
                r_pc <= w_pc_plus4;
                if (stall_b) begin
                    r_instr    <= imem_rdata;
                    r_pc_plus4 <= w_pc_plus4;
                    r_valid    <= 1'b1;
`ifdef FETCH_PERF_CNT_EN
                    r_perf_fetched <= r_perf_fetched + 32'd1;
`endif
                end else begin
                    r_skid_instr    <= imem_rdata;
                    r_skid_pc_plus4 <= w_pc_plus4;
                    r_state         <= S_HOLD;
                end
            end else if (stall_b) begin
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
`endif
            end
        end else if (stall_b) begin
            r_instr    <= r_skid_instr;
            r_pc_plus4 <= r_skid_pc_plus4;
            r_valid    <= 1'b1;
            r_state    <= S_FETCH;
`ifdef FETCH_PERF_CNT_EN
            r_perf_fetched <= r_perf_fetched + 32'd1;
`endif
        end
    end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register feeding the instruction decoder/controller. It holds the PC, issues requests to instruction memory and absorbs memory wait states. It presents one instruction per cycle to decode, or a NOP bubble when none is available. It honours decode stalls (stall_b), branch/jump redirects and halt.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (byte address, low 2 bits must be 0)
NOP_INSTR, 32'h0000_0000, encoding injected into IF/ID as a bubble

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall_b  input  1  active-low stall from hazard logic; 0 = hold IF/ID and PC
branch_taken  input  1  one-cycle pulse, redirect to branch_target
branch_target  input  32  branch destination byte address
jump  input  1  one-cycle pulse, redirect to jump_target
jump_target  input  32  jump destination byte address
halt  input  1  halt pulse/level from decode
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch byte address
imem_rdata  input  32  fetched word, valid when imem_ready=1
imem_ready  input  1  memory completes current request this cycle
if_instr  output  32  IF/ID instruction to decoder
if_pc_plus4  output  32  PC+4 of if_instr
if_valid  output  1  if_instr is a real instruction (0 = bubble)
halted  output  1  stage is halted

Behaviour:
- Reset (rst=1 at edge, overrides everything): pc=RESET_PC, state=FETCH, if_instr=NOP_INSTR, if_pc_plus4=0, if_valid=0, halted=0, skid buffer empty. After reset, imem_req=1 combinationally (state FETCH).
- imem_addr = {pc[31:2],2'b00} at all times. imem_req=1 only in FETCH. Address is held stable while imem_req=1 and imem_ready=0. imem_rdata is sampled only in a cycle with imem_req & imem_ready.
- pc+4 arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC wraps to 0. Redirect targets have bits [1:0] forced to 0.
- States:
  FETCH: if imem_ready & stall_b -> IF/ID <= {imem_rdata, pc+4, valid=1}, pc<=pc+4, stay FETCH. If imem_ready & !stall_b -> skid <= {imem_rdata, pc+4}, pc<=pc+4, IF/ID held, go HOLD. If !imem_ready & stall_b -> IF/ID <= bubble (NOP_INSTR, valid=0). If !imem_ready & !stall_b -> IF/ID held.
  HOLD: imem_req=0, IF/ID held while !stall_b. When stall_b=1 -> IF/ID <= skid (valid=1), go FETCH.
  HALTED: imem_req=0, halted=1, IF/ID = bubble; pc frozen. Exit only via rst.
- Latency: instruction whose ready arrives in cycle N appears on if_instr in N+1. Zero-wait memory sustains 1 instr/cycle.
- Redirect (branch_taken | jump) in any non-HALTED state, regardless of stall_b: pc<=target, IF/ID <= bubble, skid discarded, current memory response (if any) discarded, go FETCH. Branch_taken has priority over jump when both are asserted (older instruction).
- halt=1 (any state, not in reset): go HALTED next edge, takes priority over redirect and fetch; halted=1 from next cycle.
- stall_b=0 never drops an already-fetched instruction; at most one word is buffered (skid).

Optional Feature:
FETCH_PERF_CNT_EN: when defined, adds outputs perf_fetched[31:0] and perf_bubbles[31:0]. perf_fetched increments on every IF/ID load with valid=1. perf_bubbles increments on every IF/ID load with valid=0, excluding reset and HALTED. Both are cleared by rst and wrap at 2^32. When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=0, imem_ready=1 always, words W0..W3 at 0,4,8,C -> imem_addr 0,4,8,C on successive cycles; if_instr W0..W3 one cycle later with if_pc_plus4 4,8,C,10 and if_valid=1.
- Memory 2 wait states per fetch -> if_valid pattern 0,0,1 repeating; imem_addr held stable across wait cycles.
- stall_b=0 for 3 cycles while ready returns W1 -> if_instr stays W0; after release, W1 then W2 appear with no loss or duplication.
- branch_taken with target 0x40 during a wait state, jump with 0x80 in the same cycle -> next imem_addr=0x40, if_valid=0 for one cycle, then the word at 0x40.
- pc=0xFFFFFFFC fetch -> if_pc_plus4=0, next imem_addr=0.
- halt pulse -> halted=1 and imem_req=0 next cycle, held for 10 cycles; rst -> imem_addr=RESET_PC, halted=0.
